mux_4_1_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 datapath mux between four valid/ready requesters and delivers the selected word through a registered output stage. It supports multi-beat bursts: a requester keeps the grant until it transfers a beat with `req_last` set. The block sits in front of the combinational `mux_4_1`, driving its select and holding its result for a single downstream consumer.

---
 rtl/mux_4_1_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_mux_4_1_rr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter for four valid/ready requesters sharing one 4:1 mux.
// A requester that sends a beat without req_last keeps the grant (LOCK)
// until it sends the closing beat. The selected word is held in a registered
// output stage for a single downstream consumer.
module mux_4_1_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [3:0]       req_last,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    output logic [3:0]       req_ready,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic             out_last
);

    typedef enum logic {ARB, LOCK} state_t;

    state_t           fsm_q, fsm_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       sel_q;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_src_q, out_src_d;
    logic             out_last_q, out_last_d;

    logic [1:0]       grant;
    logic             grant_vld;
    logic             load;
    logic             xfer;
    logic [3:0]       sel_oh;
    logic [WIDTH-1:0] mux_data;

    assign load = ~out_valid_q | out_ready;

    // Grant selection: locked owner, else first valid index from ptr upward.
    always_comb begin
        grant     = sel_q;
        grant_vld = 1'b0;
        if (fsm_q == LOCK) begin
            grant     = owner_q;
            grant_vld = 1'b1;
        end else begin
            // Scan from the farthest offset down so the nearest valid wins.
            for (int k = 3; k >= 0; k--) begin
                if (req_valid[ptr_q + 2'(k)]) begin
                    grant     = ptr_q + 2'(k);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign sel       = grant;
    assign req_ready = (grant_vld & load) ? (4'b0001 << grant) : 4'b0000;
    assign xfer      = grant_vld & load & req_valid[grant];

    // Gate-level 4:1 datapath mux driven by sel.
    always_comb begin
        sel_oh[0] = ~sel[1] & ~sel[0];
        sel_oh[1] = ~sel[1] &  sel[0];
        sel_oh[2] =  sel[1] & ~sel[0];
        sel_oh[3] =  sel[1] &  sel[0];
        mux_data  = ({WIDTH{sel_oh[0]}} & req_data0)
                  | ({WIDTH{sel_oh[1]}} & req_data1)
                  | ({WIDTH{sel_oh[2]}} & req_data2)
                  | ({WIDTH{sel_oh[3]}} & req_data3);
    end

    // Next state for arbitration control and the output stage.
    always_comb begin
        fsm_d       = fsm_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_last_d  = out_last_q;
        if (load) begin
            out_valid_d = xfer;
        end
        if (xfer) begin
            out_data_d = mux_data;
            out_src_d  = grant;
            out_last_d = req_last[grant];
            if (req_last[grant]) begin
                fsm_d = ARB;
                ptr_d = grant + 2'd1;
            end else begin
                fsm_d   = LOCK;
                owner_d = grant;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q       <= ARB;
            ptr_q       <= 2'd0;
            owner_q     <= 2'd0;
            sel_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            sel_q       <= grant;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Self-checking bench for mux_4_1_rr_arbiter: directed scenarios followed by
// randomized traffic, compared against a behavioural reference model.
module tb_mux_4_1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] req_ready;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_last;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int       m_ptr, m_owner, m_sel;
    bit       m_lock;
    bit       m_ov, m_ol;
    int       m_os;
    logic [3:0] m_od;

    mux_4_1_rr_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last),
        .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
        .req_ready(req_ready), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] data_of(input int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    // Who is granted under the rules: locked owner, else first valid from ptr.
    task automatic model_grant(output int g, output bit gv);
        g  = m_sel;
        gv = 1'b0;
        if (m_lock) begin
            g  = m_owner;
            gv = 1'b1;
        end else begin
            for (int off = 0; off < 4; off++) begin
                if (!gv && req_valid[(m_ptr + off) % 4]) begin
                    g  = (m_ptr + off) % 4;
                    gv = 1'b1;
                end
            end
        end
    endtask

    // One clock: check combinational outputs, take the edge, check registers.
    task automatic step(input bit check_comb);
        int g;
        bit gv;
        bit load;
        logic [3:0] exp_rdy;
        #2;
        model_grant(g, gv);
        load = !m_ov || out_ready;
        if (check_comb) begin
            exp_rdy = (gv && load) ? (4'b0001 << g) : 4'b0000;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("sel", 32'(sel), 32'(g));
        end
        @(posedge clk);
        if (!rst) begin
            m_ptr = 0; m_owner = 0; m_sel = 0; m_lock = 0;
            m_ov = 0; m_od = 0; m_os = 0; m_ol = 0;
        end else begin
            if (gv && load && req_valid[g]) begin
                m_ov = 1; m_od = data_of(g); m_os = g; m_ol = req_last[g];
                if (req_last[g]) begin
                    m_lock = 0;
                    m_ptr  = (g + 1) % 4;
                end else begin
                    m_lock  = 1;
                    m_owner = g;
                end
            end else if (load) begin
                m_ov = 0;
            end
            if (gv) m_sel = g;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_src", 32'(out_src), 32'(m_os));
        chk("out_last", 32'(out_last), 32'(m_ol));
    endtask

    initial begin
        logic [1:0] seq_src [5];
        logic [3:0] seq_dat [5];
        seq_src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        seq_dat = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        m_ptr = 0; m_owner = 0; m_sel = 0; m_lock = 0;
        m_ov = 0; m_od = 0; m_os = 0; m_ol = 0;

        // Reset held for two cycles with all requesters valid
        rst = 1'b0; req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        step(1'b0);
        step(1'b0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // Reset priority: rotation 0,1,2,3,0
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1'b1);
            chk("rr_src", 32'(out_src), 32'(seq_src[k]));
            chk("rr_data", 32'(out_data), 32'(seq_dat[k]));
        end

        // Move ptr to 3 via a lone grant to requester 2, then wrap and skip
        req_valid = 4'b0100;
        step(1'b1);
        req_valid = 4'b0101;
        step(1'b1);
        chk("wrap_src0", 32'(out_src), 32'd0);
        step(1'b1);
        chk("wrap_src2", 32'(out_src), 32'd2);
        step(1'b1);
        chk("wrap_src0b", 32'(out_src), 32'd0);

        // Burst lock from requester 1 (ptr is now 1)
        req_valid = 4'b1111;
        req_last  = 4'b1101;
        d1 = 4'h1;
        step(1'b1);
        chk("burst_b1", 32'({out_src, out_last, out_data}), 32'({2'd1, 1'b0, 4'h1}));
        d1 = 4'h2;
        step(1'b1);
        chk("burst_b2", 32'({out_src, out_last, out_data}), 32'({2'd1, 1'b0, 4'h2}));
        d1 = 4'h3; req_last = 4'b1111;
        step(1'b1);
        chk("burst_b3", 32'({out_src, out_last, out_data}), 32'({2'd1, 1'b1, 4'h3}));
        step(1'b1);
        chk("burst_next", 32'(out_src), 32'd2);

        // Backpressure: requester 3 loads 5, then stall for three cycles
        d3 = 4'h5; d0 = 4'h7;
        step(1'b1);
        chk("bp_load", 32'(out_data), 32'h5);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            chk("bp_hold", 32'(out_data), 32'h5);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        step(1'b1);
        chk("bp_refill", 32'({out_valid, out_data}), 32'({1'b1, 4'h7}));

        // Empty: valid drops, ptr kept (next grant is requester 1)
        req_valid = 4'b0000;
        step(1'b1);
        chk("empty_valid", 32'(out_valid), 32'd0);
        req_valid = 4'b1111;
        step(1'b1);
        chk("empty_ptr", 32'(out_src), 32'd1);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            req_valid = 4'($urandom);
            req_last  = 4'($urandom) | 4'($urandom);
            d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step(1'b1);
        end

        // Reset mid-burst with requester 2 holding the lock
        out_ready = 1'b1; req_last = 4'b1111;
        req_valid = 4'b0000;
        step(1'b1);
        req_valid = 4'b0100; req_last = 4'b0000; d2 = 4'h9;
        step(1'b1);
        chk("lock_src", 32'({out_src, out_last}), 32'({2'd2, 1'b0}));
        rst = 1'b0; req_valid = 4'b1111;
        step(1'b0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        rst = 1'b1; req_last = 4'b1111; d0 = 4'h6;
        step(1'b1);
        chk("midrst_grant", 32'({out_src, out_data}), 32'({2'd0, 4'h6}));
        step(1'b1);
        chk("midrst_next", 32'(out_src), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
